// File: rtl/bin_to_bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_pkg
//  Description : Shared FSM state type and BCD digit width for bin_to_bcd.
//  Revision    : 1.0 - initial release
// ============================================================================
package bin_to_bcd_pkg;

    localparam int c_bcd_w = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_add3
//  Description : Double-dabble correction cell: adds 3 to a digit >= 5.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3
    import bin_to_bcd_pkg::*;
(
    input  logic [c_bcd_w-1:0] din,
    output logic [c_bcd_w-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= c_bcd_w'(5)) begin
            dout = din + c_bcd_w'(3);
        end
    end

endmodule
`default_nettype wire

// File: rtl/bin_to_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd
//  Description : Sequential double-dabble binary-to-BCD converter, one bit per
//                clock. Optional leading-zero mask under BIN_TO_BCD_BLANK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd
    import bin_to_bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [WIDTH-1:0]            bin,
    output logic                        busy,
    output logic                        done,
    output logic [DIGITS*c_bcd_w-1:0]   bcd
`ifdef BIN_TO_BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]           blank
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int SCR_W = DIGITS * c_bcd_w;
    localparam int ROT_W = SCR_W + WIDTH;
    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [SCR_W-1:0]   r_scratch;
    logic [CNT_W-1:0]   r_cnt;

    logic [SCR_W-1:0]   w_adj;
    logic [ROT_W-1:0]   w_rot;
    logic [SCR_W-1:0]   w_scr_next;
    logic [WIDTH-1:0]   w_shift_next;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3 u_add3 (
            .din  (r_scratch[g*c_bcd_w +: c_bcd_w]),
            .dout (w_adj[g*c_bcd_w +: c_bcd_w])
        );
    end

    // Rotate rather than shift: the bit leaving the top digit is always 0
    // because 10^DIGITS > 2^WIDTH-1, so this equals a plain left shift.
    assign w_rot        = {w_adj, r_shift};
    assign w_scr_next   = w_rot[ROT_W-2 -: SCR_W];
    assign w_shift_next = {w_rot[WIDTH-2:0], w_rot[ROT_W-1]};

`ifdef BIN_TO_BCD_BLANK_EN
    localparam logic [DIGITS-1:0] c_blank_rst = {DIGITS{1'b1}} << 1;

    logic [DIGITS-1:0] w_blank;

    for (genvar g = 0; g < DIGITS; g++) begin : g_blank
        if (g == 0) begin : g_lsd
            assign w_blank[g] = 1'b0;
        end else begin : g_upper
            assign w_blank[g] = (w_scr_next[SCR_W-1:g*c_bcd_w] == '0);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd       <= '0;
`ifdef BIN_TO_BCD_BLANK_EN
            blank     <= c_blank_rst;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= SHIFT;
                        r_shift   <= bin;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_scratch <= w_scr_next;
                    r_shift   <= w_shift_next;
                    r_cnt     <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_last_iter) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        bcd     <= w_scr_next;
`ifdef BIN_TO_BCD_BLANK_EN
                        blank   <= w_blank;
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin_to_bcd
//  Description : Self-checking bench for bin_to_bcd against a decimal model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [WIDTH-1:0]      bin = '0;
    logic                  busy;
    logic                  done;
    logic [DIGITS*4-1:0]   bcd;
`ifdef BIN_TO_BCD_BLANK_EN
    logic [DIGITS-1:0]     blank;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    bin_to_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
`ifdef BIN_TO_BCD_BLANK_EN
        ,
        .blank (blank)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal reference: digit i is (v / 10^i) mod 10.
    function automatic logic [DIGITS*4-1:0] ref_bcd(input int v);
        logic [DIGITS*4-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Digits i and above are all zero exactly when v < 10^i.
    function automatic logic [DIGITS-1:0] ref_blank(input int v);
        logic [DIGITS-1:0] r;
        int p;
        r = '0;
        p = 10;
        for (int i = 1; i < DIGITS; i++) begin
            r[i] = (v < p);
            p = p * 10;
        end
        return r;
    endfunction

    // Issue a start (caller is at #1 after an edge, DUT idle), wait for done.
    task automatic convert(input int v, input bit scramble, input int poke_at, input string tag);
        logic [DIGITS*4-1:0] prev;
        int lat;
        int busy_n;
        prev   = bcd;
        start  = 1'b1;
        bin    = WIDTH'(v);
        tick();
        start  = 1'b0;
        chk({tag, ".busy_on"}, 32'(busy), 32'd1);
        lat    = 0;
        busy_n = 0;
        while (!done && lat < 40) begin
            if (scramble) bin = WIDTH'($urandom);
            start = (lat == poke_at);
            if (lat == poke_at) bin = 16'd9999;
            if (busy) busy_n++;
            if (lat == 8) chk({tag, ".hold"}, 32'(bcd), 32'(prev));
            tick();
            lat++;
        end
        start = 1'b0;
        chk({tag, ".latency"}, 32'(lat), 32'(WIDTH));
        chk({tag, ".busy_cycles"}, 32'(busy_n), 32'(WIDTH));
        chk({tag, ".busy_off"}, 32'(busy), 32'd0);
        chk({tag, ".bcd"}, 32'(bcd), 32'(ref_bcd(v)));
`ifdef BIN_TO_BCD_BLANK_EN
        chk({tag, ".blank"}, 32'(blank), 32'(ref_blank(v)));
`endif
    endtask

    initial begin
        int first_done;
        int vals[10];
        vals = '{9, 10, 99, 100, 999, 1000, 9999, 10000, 59999, 65534};

        // Reset state
        #2;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.bcd", 32'(bcd), 32'd0);
`ifdef BIN_TO_BCD_BLANK_EN
        chk("rst.blank", 32'(blank), 32'h1E);
`endif
        tick();
        tick();
        rst = 1'b0;

        // Zero, then full scale
        convert(0, 1'b0, -1, "zero");
        tick();
        chk("zero.done_pulse", 32'(done), 32'd0);
        convert(65535, 1'b0, -1, "max");
        tick();

        // Start during SHIFT is ignored
        convert(42, 1'b0, 5, "ignore");
        tick();
        chk("ignore.idle", 32'(busy), 32'd0);

        // Back-to-back: start held in the done cycle
        convert(1234, 1'b0, -1, "b2b_a");
        first_done = cyc;
        convert(9999, 1'b0, -1, "b2b_b");
        chk("b2b.spacing", 32'(cyc - first_done), 32'(WIDTH + 1));

        // Reset mid-conversion
        tick();
        start = 1'b1;
        bin   = 16'd500;
        tick();
        start = 1'b0;
        repeat (8) tick();
        #2 rst = 1'b1;
        #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.bcd", 32'(bcd), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("abort.no_done", 32'(done), 32'd0);
        end
        rst = 1'b0;
        convert(500, 1'b0, -1, "after_rst");

        // Decimal boundaries, bin scrambled after acceptance
        foreach (vals[i]) convert(vals[i], 1'b1, -1, "edge");

        // Random back-to-back sweep
        for (int i = 0; i < 250; i++) begin
            convert(int'($urandom_range(0, 65535)), 1'b1, -1, "rand");
        end
        tick();
        chk("final.done_low", 32'(done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
